// File: rtl/bmc_pkg.sv
// Shared helpers for the soft-decision branch-metric unit: widths, per-bit
// distance and the codeword bit-select used when summing metrics.
package bmc_pkg;

  // Working width for distance arithmetic; covers any legal SOFT_W.
  localparam int DIST_W = 16;

  function automatic int bm_width(input int n, input int soft_w);
    return soft_w + $clog2(n);
  endfunction

  function automatic logic [DIST_W-1:0] soft_max(input int soft_w);
    return DIST_W'((1 << soft_w) - 1);
  endfunction

  // Distance of soft value s from ideal bit b; an erased bit carries no evidence.
  function automatic logic [DIST_W-1:0] bit_dist(input logic [DIST_W-1:0] s,
                                                 input logic b,
                                                 input logic punct,
                                                 input int soft_w);
    logic [DIST_W-1:0] d;
    d = b ? (soft_max(soft_w) - s) : s;
    return punct ? '0 : d;
  endfunction

  // Code bit i expected by codeword index c.
  function automatic logic cw_bit(input int c, input int i);
    return c[i];
  endfunction

endpackage

// File: rtl/bmc_bit_dist.sv
// Per-bit combinational distance pair d(i,0), d(i,1) for one soft code bit,
// forced to zero when the bit is punctured.
module bmc_bit_dist
  import bmc_pkg::*;
#(
  parameter int SOFT_W = 3
) (
  input  logic [SOFT_W-1:0] s,
  input  logic              punct,
  output logic [SOFT_W-1:0] d0,
  output logic [SOFT_W-1:0] d1
);

  assign d0 = SOFT_W'(bit_dist(DIST_W'(s), 1'b0, punct, SOFT_W));
  assign d1 = SOFT_W'(bit_dist(DIST_W'(s), 1'b1, punct, SOFT_W));

endmodule

// File: rtl/bmc_soft_pipe.sv
// Two-stage pipelined branch-metric unit: per-bit distances, then 2^N sums,
// with valid/ready back-pressure. Optional erasure input under BMC_PUNCTURE_EN.
module bmc_soft_pipe
  import bmc_pkg::*;
#(
  parameter  int N      = 2,
  parameter  int SOFT_W = 3,
  localparam int BM_W   = bm_width(N, SOFT_W)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*SOFT_W-1:0]       in_sym,
  input  logic                      in_last,
`ifdef BMC_PUNCTURE_EN
  input  logic [N-1:0]              in_punct,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(2**N)*BM_W-1:0]    out_bm,
  output logic                      out_last
);

  localparam int NCW = 2 ** N;

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid holds with stable data until accepted, ready may depend on the
  // downstream ready (in_ready follows out_ready combinationally).

  logic [N-1:0] punct;
`ifdef BMC_PUNCTURE_EN
  assign punct = in_punct;
`else
  assign punct = '0;
`endif

  logic [SOFT_W-1:0] d0_w [N];
  logic [SOFT_W-1:0] d1_w [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    bmc_bit_dist #(.SOFT_W(SOFT_W)) u_bit_dist (
      .s     (in_sym[gi*SOFT_W +: SOFT_W]),
      .punct (punct[gi]),
      .d0    (d0_w[gi]),
      .d1    (d1_w[gi])
    );
  end

  logic              s1_valid;
  logic              s1_last;
  logic [SOFT_W-1:0] s1_d0 [N];
  logic [SOFT_W-1:0] s1_d1 [N];

  logic                 s2_valid;
  logic                 s2_last;
  logic [NCW*BM_W-1:0]  s2_bm;
  logic [NCW*BM_W-1:0]  sum_w;

  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        s1_d0[i] <= '0;
        s1_d1[i] <= '0;
      end
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_last <= in_last;
        for (int i = 0; i < N; i++) begin
          s1_d0[i] <= d0_w[i];
          s1_d1[i] <= d1_w[i];
        end
      end
    end
  end

  // Each codeword sums the distance matching its expected bit at every position.
  always_comb begin
    logic [BM_W-1:0] acc;
    sum_w = '0;
    acc   = '0;
    for (int c = 0; c < NCW; c++) begin
      acc = '0;
      for (int i = 0; i < N; i++) begin
        acc = acc + BM_W'(cw_bit(c, i) ? s1_d1[i] : s1_d0[i]);
      end
      sum_w[c*BM_W +: BM_W] = acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_bm    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_last <= s1_last;
        s2_bm   <= sum_w;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_bm    = s2_bm;
  assign out_last  = s2_last;

endmodule
